// File: rtl/traffic_phase_timer.sv
// ---------------------------------------------------------------------------
// traffic_phase_timer
//   Timed sequencer for one traffic lamp head: RED -> GREEN -> YELLOW -> RED.
//   Each phase has its own duration. A pedestrian request extends the next
//   RED by PED_CYCLES and raises WALK for that whole RED.
//
//   Optional feature macro: NIGHT_FLASH_EN
//     defined   : night=1 at any phase end enters a flashing-yellow state
//     undefined : the night input is present but ignored
//
// Ports
//   clk         in   1  system clock, all state updates on posedge
//   rst_n       in   1  asynchronous active-low reset
//   ped_req     in   1  pedestrian request (level, sampled every posedge)
//   night       in   1  night-mode request (used only with NIGHT_FLASH_EN)
//   light       out  3  one-hot lamp bus (RED=001, GREEN=010, YELLOW=100)
//   walk        out  1  pedestrian WALK indicator
//   ped_ack     out  1  one-cycle pulse when a pending request is granted
//   phase_done  out  1  one-cycle pulse in the first cycle of every new phase
// ---------------------------------------------------------------------------
module traffic_phase_timer #(
    parameter int RED_CYCLES    = 5,
    parameter int GREEN_CYCLES  = 4,
    parameter int YELLOW_CYCLES = 2,
    parameter int PED_CYCLES    = 3,
    parameter int FLASH_CYCLES  = 2,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ped_req,
    input  logic       night,
    output logic [2:0] light,
    output logic       walk,
    output logic       ped_ack,
    output logic       phase_done
);

    localparam logic [2:0] L_RED    = 3'b001;
    localparam logic [2:0] L_GREEN  = 3'b010;
    localparam logic [2:0] L_YELLOW = 3'b100;
    localparam logic [2:0] L_OFF    = 3'b000;

    // Counter reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [CNT_W-1:0] RED_LOAD    = CNT_W'(RED_CYCLES - 1);
    localparam logic [CNT_W-1:0] RED_PED_LOAD = CNT_W'(RED_CYCLES + PED_CYCLES - 1);
    localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLASH_LOAD  = CNT_W'(FLASH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

`ifdef NIGHT_FLASH_EN
    typedef enum logic [1:0] {
        S_RED    = 2'd0,
        S_GREEN  = 2'd1,
        S_YELLOW = 2'd2,
        S_FLASH  = 2'd3
    } state_t;
`else
    // Code 2'd3 is unused here and falls into the illegal-state recovery.
    typedef enum logic [1:0] {
        S_RED    = 2'd0,
        S_GREEN  = 2'd1,
        S_YELLOW = 2'd2
    } state_t;

    // night and FLASH_CYCLES have no function in this build.
    logic             unused_night;
    logic [CNT_W-1:0] unused_flash_load;
    assign unused_night      = night;
    assign unused_flash_load = FLASH_LOAD;
`endif

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       light_reg, light_next;
    logic             walk_reg, walk_next;
    logic             ped_ack_reg, ped_ack_next;
    logic             phase_done_reg, phase_done_next;
    logic             pending_reg, pending_next;

    // A request on the very edge that enters RED counts, hence the OR with
    // the live input rather than only the stored flag.
    logic             serve;
    assign serve = pending_reg | ped_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_RED;
            cnt_reg        <= RED_LOAD;
            light_reg      <= L_RED;
            walk_reg       <= 1'b0;
            ped_ack_reg    <= 1'b0;
            phase_done_reg <= 1'b0;
            pending_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            light_reg      <= light_next;
            walk_reg       <= walk_next;
            ped_ack_reg    <= ped_ack_next;
            phase_done_reg <= phase_done_next;
            pending_reg    <= pending_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg - CNT_ONE;
        light_next      = light_reg;
        walk_next       = walk_reg;
        ped_ack_next    = 1'b0;
        phase_done_next = 1'b0;
        pending_next    = pending_reg | ped_req;

        case (state_reg)
            S_RED: begin
                if (cnt_reg == '0) begin
                    state_next      = S_GREEN;
                    cnt_next        = GREEN_LOAD;
                    light_next      = L_GREEN;
                    walk_next       = 1'b0;
                    phase_done_next = 1'b1;
                end
            end
            S_GREEN: begin
                if (cnt_reg == '0) begin
                    state_next      = S_YELLOW;
                    cnt_next        = YELLOW_LOAD;
                    light_next      = L_YELLOW;
                    phase_done_next = 1'b1;
                end
            end
            S_YELLOW: begin
                if (cnt_reg == '0) begin
                    state_next      = S_RED;
                    light_next      = L_RED;
                    phase_done_next = 1'b1;
                    if (serve) begin
                        cnt_next     = RED_PED_LOAD;
                        walk_next    = 1'b1;
                        ped_ack_next = 1'b1;
                        pending_next = 1'b0;
                    end else begin
                        cnt_next  = RED_LOAD;
                        walk_next = 1'b0;
                    end
                end
            end
`ifdef NIGHT_FLASH_EN
            S_FLASH: begin
                if (cnt_reg == '0) begin
                    if (night) begin
                        // Same phase, next half-period: no phase_done.
                        cnt_next   = FLASH_LOAD;
                        light_next = (light_reg == L_YELLOW) ? L_OFF : L_YELLOW;
                    end else begin
                        state_next      = S_RED;
                        light_next      = L_RED;
                        phase_done_next = 1'b1;
                        if (serve) begin
                            cnt_next     = RED_PED_LOAD;
                            walk_next    = 1'b1;
                            ped_ack_next = 1'b1;
                            pending_next = 1'b0;
                        end else begin
                            cnt_next  = RED_LOAD;
                            walk_next = 1'b0;
                        end
                    end
                end
            end
`endif
            default: begin
                // Recover from an unreachable encoding into a fresh RED.
                state_next      = S_RED;
                cnt_next        = RED_LOAD;
                light_next      = L_RED;
                walk_next       = 1'b0;
                phase_done_next = 1'b1;
            end
        endcase

`ifdef NIGHT_FLASH_EN
        // Night request overrides the normal successor of any timed phase;
        // pending is kept so a waiting pedestrian is served after the night.
        if (night && cnt_reg == '0 &&
            (state_reg == S_RED || state_reg == S_GREEN || state_reg == S_YELLOW)) begin
            state_next      = S_FLASH;
            cnt_next        = FLASH_LOAD;
            light_next      = L_YELLOW;
            walk_next       = 1'b0;
            ped_ack_next    = 1'b0;
            phase_done_next = 1'b1;
            pending_next    = pending_reg | ped_req;
        end
`endif
    end

    assign light      = light_reg;
    assign walk       = walk_reg;
    assign ped_ack    = ped_ack_reg;
    assign phase_done = phase_done_reg;

endmodule
